// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and derived totals for the scan generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CW_DEF       = 10;

  function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int vga_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int H_TOTAL_DEF = vga_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = vga_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-output bundle: pixel enable in, position/sync/strobe outputs out.
interface vga_scan_gen_if #(parameter int CW = vga_pkg::CW_DEF);
  logic          ce;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_start;
  logic          frame_start;

  modport master (input ce, output hcnt, vcnt, hsync, vsync, de, line_start, frame_start);
  modport slave  (output ce, input hcnt, vcnt, hsync, vsync, de, line_start, frame_start);
endinterface

// File: rtl/cnt_up_wrap.sv
// Up-counter 0..MAX with enable, sync active-low reset to RST_VAL, and a carry on wrap.
module cnt_up_wrap #(
  parameter int          CW      = 10,
  parameter logic [CW-1:0] MAX     = '1,
  parameter logic [CW-1:0] RST_VAL = MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_nxt_o,
  output logic          wrap_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (ce_i) begin
      if (cnt_q == MAX) begin
        cnt_d  = '0;
        wrap_o = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  // Next value is exported so the owner can register decodes with zero skew.
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: h/v counters plus registered sync, display-enable and start strobes.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = CW_DEF
) (
  input logic              clk,
  input logic              rst_n,
  vga_scan_gen_if.master   bus
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((64'(1) << CW) < 64'(vga_max(H_TOTAL, V_TOTAL))) begin : g_cw_chk
    $error("vga_scan_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_q, h_nxt, v_q, v_nxt;
  logic          h_wrap, v_wrap, v_ce;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;

  cnt_up_wrap #(.CW(CW), .MAX(CW'(H_TOTAL - 1))) u_hcnt (
    .clk, .rst_n, .ce_i(bus.ce), .cnt_o(h_q), .cnt_nxt_o(h_nxt), .wrap_o(h_wrap)
  );

  assign v_ce = bus.ce & h_wrap;

  cnt_up_wrap #(.CW(CW), .MAX(CW'(V_TOTAL - 1))) u_vcnt (
    .clk, .rst_n, .ce_i(v_ce), .cnt_o(v_q), .cnt_nxt_o(v_nxt), .wrap_o(v_wrap)
  );

  // Decode the next position so the registered flags line up with the counters.
  always_comb begin
    hs_d = ~SYNC_POL;
    vs_d = ~SYNC_POL;
    if (h_nxt >= CW'(H_ACTIVE + H_FP) && h_nxt < CW'(H_ACTIVE + H_FP + H_SYNC)) hs_d = SYNC_POL;
    if (v_nxt >= CW'(V_ACTIVE + V_FP) && v_nxt < CW'(V_ACTIVE + V_FP + V_SYNC)) vs_d = SYNC_POL;
    de_d = (h_nxt < CW'(H_ACTIVE)) && (v_nxt < CW'(V_ACTIVE));
    ls_d = h_wrap;
    fs_d = h_wrap & v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign bus.hcnt        = h_q;
  assign bus.vcnt        = v_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.de          = de_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: default 640x480 instance plus a tiny active-high instance for full-frame checks.
module tb_vga_scan_gen;
  import vga_pkg::*;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic hs, vs, de, ls, fs;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  vga_scan_gen_if #(.CW(CW_DEF)) bus0 ();
  vga_scan_gen_if #(.CW(5))      bus1 ();
  assign bus0.ce = ce;
  assign bus1.ce = ce;

  vga_scan_gen dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  vga_scan_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b1), .CW(5)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int   tests = 0;
  int   fails = 0;
  st_t  m0, m1;
  st_t  q0[$], q1[$];

  function automatic st_t nxt(input st_t c, input logic r, input logic e,
                              input int ha, input int hfp, input int hsy, input int hbp,
                              input int va, input int vfp, input int vsy, input int vbp,
                              input logic pol);
    int ht = ha + hfp + hsy + hbp;
    int vt = va + vfp + vsy + vbp;
    int h, v;
    st_t n;
    n = '0;
    if (!r) begin
      n.h = 16'(ht - 1); n.v = 16'(vt - 1);
      n.hs = !pol; n.vs = !pol;
      return n;
    end
    h = int'(c.h); v = int'(c.v);
    if (e) begin
      if (h == ht - 1) begin
        h = 0; n.ls = 1'b1;
        if (v == vt - 1) begin v = 0; n.fs = 1'b1; end
        else v = v + 1;
      end else h = h + 1;
    end
    n.h  = 16'(h); n.v = 16'(v);
    n.de = (h < ha) && (v < va);
    n.hs = (h >= ha + hfp && h < ha + hfp + hsy) ? pol : !pol;
    n.vs = (v >= va + vfp && v < va + vfp + vsy) ? pol : !pol;
    return n;
  endfunction

  function automatic st_t obs0();
    st_t o;
    o.h = 16'(bus0.hcnt); o.v = 16'(bus0.vcnt);
    o.hs = bus0.hsync; o.vs = bus0.vsync; o.de = bus0.de;
    o.ls = bus0.line_start; o.fs = bus0.frame_start;
    return o;
  endfunction

  function automatic st_t obs1();
    st_t o;
    o.h = 16'(bus1.hcnt); o.v = 16'(bus1.vcnt);
    o.hs = bus1.hsync; o.vs = bus1.vsync; o.de = bus1.de;
    o.ls = bus1.line_start; o.fs = bus1.frame_start;
    return o;
  endfunction

  task automatic chk(input string tag, input st_t o, input st_t x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
             tag, o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs, x.h, x.v, x.hs, x.vs, x.de, x.ls, x.fs);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s got %0d want %0d", tag, o, x);
    end
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input logic r, input logic e);
    rst_n = r; ce = e;
    m0 = nxt(m0, r, e, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
             V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF, 1'b0);
    m1 = nxt(m1, r, e, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk); #1;
    chk("dut0", obs0(), q0.pop_front());
    chk("dut1", obs1(), q1.pop_front());
  endtask

  initial begin
    int cnt, h0, vs_n;
    int fs_t[$], ls_t[$];
    m0 = '0; m1 = '0;

    // Reset regardless of ce
    step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk_int("rst_h", int'(bus0.hcnt), 799);
    chk_int("rst_v", int'(bus0.vcnt), 524);
    chk_int("rst_de_hs_vs_ls_fs", {bus0.de, bus0.hsync, bus0.vsync, bus0.line_start, bus0.frame_start}, 5'b01100);

    // First ce after reset lands on (0,0) with both strobes for one clk
    step(1'b1, 1'b1);
    chk_int("first_pos", {int'(bus0.hcnt), int'(bus0.vcnt)}, 0);
    chk_int("first_flags", {bus0.de, bus0.line_start, bus0.frame_start}, 3'b111);
    step(1'b1, 1'b0);
    chk_int("first_pulse_off", {bus0.line_start, bus0.frame_start}, 0);

    // hsync window
    step(1'b0, 1'b0);
    for (int i = 0; i < 656; i++) step(1'b1, 1'b1);
    chk_int("h655", int'(bus0.hcnt), 655);
    chk_int("hs_off_655", int'(bus0.hsync), 1);
    step(1'b1, 1'b1);
    chk_int("h656", int'(bus0.hcnt), 656);
    chk_int("hs_on_656", int'(bus0.hsync), 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus0.hsync == 1'b0) cnt++;
      step(1'b1, 1'b1);
    end
    chk_int("hs_width", cnt, 96);

    // ce toggling: advance only on ce=1, strobes never with ce=0
    for (int i = 0; i < 4; i++) begin
      h0 = int'(bus0.hcnt);
      step(1'b1, 1'(i % 2 == 0));
      chk_int("toggle_h", int'(bus0.hcnt), (i % 2 == 0) ? h0 + 1 : h0);
      if (i % 2 == 1) chk_int("toggle_no_pulse", {bus0.line_start, bus0.frame_start}, 0);
    end
    for (int i = 0; i < 300; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // Mid-frame reset with ce=1
    for (int i = 0; i < 2000 && !(bus0.hcnt == 10'd300 && bus0.vcnt != 10'd0); i++) step(1'b1, 1'b1);
    chk_int("seek300", int'(bus0.hcnt), 300);
    step(1'b0, 1'b1);
    chk_int("midrst_pos", {int'(bus0.hcnt[9:0]), int'(bus0.vcnt[9:0])}, {32'd799, 32'd524});
    chk_int("midrst_flags", {bus0.de, bus0.hsync, bus0.vsync}, 3'b011);

    // Small instance: active-area edge and frame wrap
    for (int i = 0; i < 400 && !(bus1.hcnt == 5'(S_HA - 1) && bus1.vcnt == 5'(S_VA - 1)); i++) step(1'b1, 1'b1);
    chk_int("seek_last_act", int'(bus1.de), 1);
    step(1'b1, 1'b1);
    chk_int("de_off_pos", int'(bus1.hcnt), S_HA);
    chk_int("de_off", int'(bus1.de), 0);
    for (int i = 0; i < 400 && !(bus1.hcnt == 5'(S_HT - 1) && bus1.vcnt == 5'(S_VT - 1)); i++) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_int("wrap_pos", int'(bus1.hcnt) + int'(bus1.vcnt), 0);
    chk_int("wrap_pulses", {bus1.line_start, bus1.frame_start}, 2'b11);

    // Two-plus frames continuous: strobe spacing and vsync width
    step(1'b0, 1'b0);
    vs_n = 0;
    for (int c = 0; c <= 3 * S_HT * S_VT; c++) begin
      step(1'b1, 1'b1);
      if (bus1.frame_start) fs_t.push_back(c);
      if (bus1.line_start)  ls_t.push_back(c);
      if (fs_t.size() == 1 && bus1.vsync) vs_n++;
    end
    chk_int("fs_count", fs_t.size(), 4);
    chk_int("ls_count", ls_t.size(), 3 * S_VT + 1);
    if (fs_t.size() >= 3) begin
      chk_int("fs_period0", fs_t[1] - fs_t[0], S_HT * S_VT);
      chk_int("fs_period1", fs_t[2] - fs_t[1], S_HT * S_VT);
    end
    if (ls_t.size() >= 2) chk_int("ls_period", ls_t[1] - ls_t[0], S_HT);
    chk_int("vs_width", vs_n, S_VS * S_HT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, SHALL set the horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480, SHALL set the visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, SHALL set the vertical front porch, sync and back porch, in lines.
REQ-005 Parameter SYNC_POL, default 0, SHALL set the asserted sync level (0 = active-low).
REQ-006 Parameter CW, default 10, SHALL be the counter width; elaboration SHALL fail if 2^CW < max(H_TOTAL, V_TOTAL).
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 ce  input  1  pixel enable; the scan advances one pixel per clk with ce=1.
REQ-010 hcnt  output  CW  horizontal position, 0..H_TOTAL-1.
REQ-011 vcnt  output  CW  vertical position, 0..V_TOTAL-1.
REQ-012 hsync  output  1  horizontal sync, level per SYNC_POL.
REQ-013 vsync  output  1  vertical sync, level per SYNC_POL.
REQ-014 de  output  1  display enable, high inside the active area.
REQ-015 line_start  output  1  one-clk pulse when hcnt advances to 0.
REQ-016 frame_start  output  1  one-clk pulse when (hcnt,vcnt) advances to (0,0).

Function
REQ-017 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-018 On a clk edge with ce=1, hcnt SHALL increment by 1, wrapping from H_TOTAL-1 to 0.
REQ-019 vcnt SHALL increment only on an edge where hcnt wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-020 With ce=0, hcnt, vcnt, hsync, vsync and de SHALL hold their values, and both pulse outputs SHALL be 0.
REQ-021 de SHALL be 1 iff hcnt < H_ACTIVE and vcnt < V_ACTIVE.
REQ-022 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-023 vsync SHALL be asserted iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-024 hsync, vsync and de SHALL be registers computed from the next counter values, so they align with hcnt/vcnt with zero skew and no combinational path from the counters.
REQ-025 line_start and frame_start SHALL be registered and high in the same cycle the counters first show the new position.
REQ-026 On a simultaneous h- and v-wrap, line_start and frame_start SHALL both pulse.
REQ-027 With ce held high, frame_start SHALL pulse exactly once every H_TOTAL*V_TOTAL clks (420000).

Reset
REQ-028 While rst_n=0 at a clk edge: hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, de=0, hsync and vsync deasserted, line_start=0, frame_start=0, regardless of ce.
REQ-029 Reset SHALL take priority over ce; asserting it mid-frame SHALL return to the REQ-028 state at the next edge.
REQ-030 The first ce=1 edge after reset SHALL move to (0,0), with de=1 and line_start=frame_start=1.

Structure
REQ-031 Default timing constants, H_TOTAL/V_TOTAL derivation and CW SHALL live in shared package vga_pkg.
REQ-032 Both counters SHALL be instances of one sub-module, cnt_up_wrap (up-counter with ce, MAX parameter, synchronous active-low reset to a parameter value, and a wrap/carry output).
REQ-033 The vertical instance's ce SHALL be ce AND the horizontal instance's wrap.

Verification
REQ-034 Reset, then one ce pulse -> (hcnt,vcnt)=(0,0), de=1, line_start=1, frame_start=1 for that clk only.
REQ-035 ce=1 for 656 clks after reset -> hcnt=655 with hsync deasserted; next ce -> hcnt=656 with hsync asserted; asserted for exactly 96 ce cycles.
REQ-036 ce toggled 1,0,1,0 -> counters advance only on ce=1 edges; pulses never high while ce=0.
REQ-037 ce=1 continuously for two frames -> frame_start pulses exactly 420000 clks apart; line_start pulses exactly 800 clks apart; vsync asserted for exactly 1600 clks per frame.
REQ-038 rst_n low at (hcnt,vcnt)=(300,200) with ce=1 -> next edge gives (799,524), de=0, syncs deasserted.
REQ-039 Scan at (639,479) -> next ce gives de=0 at (640,479); at (799,524) -> next ce gives (0,0) with both pulses high.
